// File: rtl/lsu_pkg.sv
// Shared types, widths and byte-mask constants for the LSU memory master.
// Size encoding, FSM states and request payload live here so the top and the extender agree.
package lsu_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned MEM_AW  = 11;
   localparam int unsigned BMASK_W = 4;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_ILL  = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_ACCESS = 2'b01,
      S_SPLIT  = 2'b10,
      S_RESP   = 2'b11
   } state_e;

   localparam logic [BMASK_W-1:0] BMASK_BYTE = 4'b0001;
   localparam logic [BMASK_W-1:0] BMASK_HALF = 4'b0011;
   localparam logic [BMASK_W-1:0] BMASK_WORD = 4'b1111;

   // Request fields held for the duration of one transaction.
   typedef struct packed {
      logic [MEM_AW-1:0] addr;
      size_e             size;
      logic              wren;
      logic              uns;
      logic [DATA_W-1:0] wdata;
   } req_t;

   function automatic logic [BMASK_W-1:0] size_bmask(input size_e size);
      case (size)
         SIZE_HALF: return BMASK_HALF;
         SIZE_WORD: return BMASK_WORD;
         default:   return BMASK_BYTE;
      endcase
   endfunction

   // Expand a byte mask into a per-bit data mask.
   function automatic logic [DATA_W-1:0] bmask_bits(input logic [BMASK_W-1:0] mask);
      logic [DATA_W-1:0] bits;
      bits = '0;
      for (int i = 0; i < int'(BMASK_W); i++) begin
         bits[8*i +: 8] = {8{mask[i]}};
      end
      return bits;
   endfunction

   function automatic logic misaligned(input size_e size, input logic [1:0] lsb);
      return ((size == SIZE_HALF) && lsb[0]) || ((size == SIZE_WORD) && (lsb != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension: byte/half sign- or zero-extended, word passed through.
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [DATA_W-1:0] raw,
   input  size_e             size,
   input  logic              uns,
   output logic [DATA_W-1:0] data_c
);

   always_comb begin
      data_c = raw;
      case (size)
         SIZE_BYTE: data_c = {{(DATA_W-8){~uns & raw[7]}}, raw[7:0]};
         SIZE_HALF: data_c = {{(DATA_W-16){~uns & raw[15]}}, raw[15:0]};
         default:   data_c = raw;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit master onto a 2 KiB byte-addressed memory with one-cycle combinational read.
// Define LSU_MISALIGN_SPLIT_EN to break misaligned half/word accesses into byte accesses.
module lsu_mem_master
   import lsu_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic [ADDR_W-1:0]  i_req_addr,
   input  logic               i_req_wren,
   input  logic [1:0]         i_req_size,
   input  logic               i_req_unsigned,
   input  logic [DATA_W-1:0]  i_req_wdata,
   output logic               o_rsp_valid,
   input  logic               i_rsp_ready,
   output logic [DATA_W-1:0]  o_rsp_rdata,
   output logic               o_rsp_err,
   output logic [MEM_AW-1:0]  o_mem_addr,
   output logic [DATA_W-1:0]  o_mem_wdata,
   output logic [BMASK_W-1:0] o_mem_bmask,
   output logic               o_mem_wren,
   input  logic [DATA_W-1:0]  i_mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   state_e             state, state_n;
   req_t               req, req_n;
   logic               split, split_n;
   logic [1:0]         cnt, cnt_n;
   logic [DATA_W-1:0]  raw, raw_n;

   logic               ready_n, rsp_valid_n, rsp_err_n, mem_wren_n;
   logic [DATA_W-1:0]  rsp_rdata_n, mem_wdata_n;
   logic [MEM_AW-1:0]  mem_addr_n;
   logic [BMASK_W-1:0] mem_bmask_n;

   size_e              in_size;
   logic               in_mis, in_illegal;
   logic [1:0]         cnt_nxt, cnt_last;
   logic [DATA_W-1:0]  assembled, ext_in, ext_data;

   // Incoming request classification.
   always_comb begin
      in_size    = size_e'(i_req_size);
      in_mis     = misaligned(in_size, i_req_addr[1:0]);
      in_illegal = (in_size == SIZE_ILL) || (i_req_addr[ADDR_W-1:MEM_AW] != '0) ||
                   (in_mis && !SPLIT_EN);
   end

   // Split bookkeeping: byte k of a misaligned load lands in bits [8k+7:8k].
   always_comb begin
      cnt_nxt   = 2'(cnt + 2'd1);
      cnt_last  = (req.size == SIZE_WORD) ? 2'd3 : 2'd1;
      assembled = raw;
      assembled[{cnt, 3'b000} +: 8] = i_mem_rdata[7:0];
      ext_in    = split ? assembled : i_mem_rdata;
   end

   lsu_load_ext u_load_ext (
      .raw    (ext_in),
      .size   (req.size),
      .uns    (req.uns),
      .data_c (ext_data)
   );

   // Next-state and next-output logic; memory strobes default to idle every cycle.
   always_comb begin
      state_n     = state;
      req_n       = req;
      split_n     = split;
      cnt_n       = cnt;
      raw_n       = raw;
      ready_n     = 1'b0;
      rsp_valid_n = o_rsp_valid;
      rsp_rdata_n = o_rsp_rdata;
      rsp_err_n   = o_rsp_err;
      mem_addr_n  = '0;
      mem_wdata_n = '0;
      mem_bmask_n = '0;
      mem_wren_n  = 1'b0;

      case (state)
         S_IDLE: begin
            ready_n = 1'b1;
            if (i_req_valid && o_req_ready) begin
               ready_n = 1'b0;
               req_n   = '{addr:  i_req_addr[MEM_AW-1:0],
                           size:  in_size,
                           wren:  i_req_wren,
                           uns:   i_req_unsigned,
                           wdata: i_req_wdata};
               split_n = in_mis;
               cnt_n   = '0;
               raw_n   = '0;
               if (in_illegal) begin
                  state_n     = S_RESP;
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
                  rsp_rdata_n = '0;
               end else begin
                  state_n    = S_ACCESS;
                  mem_addr_n = i_req_addr[MEM_AW-1:0];
                  mem_wren_n = i_req_wren;
                  if (in_mis) begin
                     mem_bmask_n = BMASK_BYTE;
                     mem_wdata_n = DATA_W'(i_req_wdata[7:0]);
                  end else begin
                     mem_bmask_n = size_bmask(in_size);
                     mem_wdata_n = i_req_wdata & bmask_bits(size_bmask(in_size));
                  end
               end
            end
         end

         // ACCESS issues the single aligned access or split byte 0; SPLIT issues bytes 1..N-1.
         S_ACCESS, S_SPLIT: begin
            if (!split || (cnt == cnt_last)) begin
               state_n     = S_RESP;
               rsp_valid_n = 1'b1;
               rsp_err_n   = 1'b0;
               rsp_rdata_n = req.wren ? '0 : ext_data;
               raw_n       = assembled;
            end else begin
               state_n     = S_SPLIT;
               raw_n       = assembled;
               cnt_n       = cnt_nxt;
               mem_addr_n  = MEM_AW'(req.addr + MEM_AW'(cnt_nxt));
               mem_bmask_n = BMASK_BYTE;
               mem_wren_n  = req.wren;
               mem_wdata_n = DATA_W'(req.wdata[{cnt_nxt, 3'b000} +: 8]);
            end
         end

         S_RESP: begin
            if (i_rsp_ready) begin
               state_n     = S_IDLE;
               rsp_valid_n = 1'b0;
               rsp_err_n   = 1'b0;
               rsp_rdata_n = '0;
               ready_n     = 1'b1;
            end
         end

         default: state_n = S_IDLE;
      endcase
   end

   // All state and outputs registered; reset abandons any transaction in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         req         <= '0;
         split       <= 1'b0;
         cnt         <= '0;
         raw         <= '0;
         o_req_ready <= 1'b0;
         o_rsp_valid <= 1'b0;
         o_rsp_rdata <= '0;
         o_rsp_err   <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_bmask <= '0;
         o_mem_wren  <= 1'b0;
      end else begin
         state       <= state_n;
         req         <= req_n;
         split       <= split_n;
         cnt         <= cnt_n;
         raw         <= raw_n;
         o_req_ready <= ready_n;
         o_rsp_valid <= rsp_valid_n;
         o_rsp_rdata <= rsp_rdata_n;
         o_rsp_err   <= rsp_err_n;
         o_mem_addr  <= mem_addr_n;
         o_mem_wdata <= mem_wdata_n;
         o_mem_bmask <= mem_bmask_n;
         o_mem_wren  <= mem_wren_n;
      end
   end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: byte-array reference model, expected-access and
// expected-response queues checked by a monitor independent of the stimulus thread.
module tb_lsu_mem_master;
   import lsu_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   logic        i_clk, i_rst_n;
   logic        i_req_valid, o_req_ready, i_req_wren, i_req_unsigned;
   logic [31:0] i_req_addr, i_req_wdata;
   logic [1:0]  i_req_size;
   logic        o_rsp_valid, i_rsp_ready, o_rsp_err;
   logic [31:0] o_rsp_rdata;
   logic [10:0] o_mem_addr;
   logic [31:0] o_mem_wdata, i_mem_rdata;
   logic [3:0]  o_mem_bmask;
   logic        o_mem_wren;

   lsu_mem_master dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_addr     (i_req_addr),
      .i_req_wren     (i_req_wren),
      .i_req_size     (i_req_size),
      .i_req_unsigned (i_req_unsigned),
      .i_req_wdata    (i_req_wdata),
      .o_rsp_valid    (o_rsp_valid),
      .i_rsp_ready    (i_rsp_ready),
      .o_rsp_rdata    (o_rsp_rdata),
      .o_rsp_err      (o_rsp_err),
      .o_mem_addr     (o_mem_addr),
      .o_mem_wdata    (o_mem_wdata),
      .o_mem_bmask    (o_mem_bmask),
      .o_mem_wren     (o_mem_wren),
      .i_mem_rdata    (i_mem_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } rsp_t;

   typedef struct {
      logic [10:0] addr;
      logic [3:0]  bmask;
      logic        wren;
      logic [31:0] wdata;
   } acc_t;

   rsp_t        rsp_q[$];
   acc_t        acc_q[$];
   logic [7:0]  ref_mem [0:2047];
   logic [7:0]  mem     [0:2047];
   bit          mem_ready = 1'b0;
   bit          first_seen = 1'b0;
   bit          hold_low = 1'b0;
   int          cyc = 0;
   int          hs_cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 37 + 11) ^ (i >> 3));
   endfunction

   function automatic logic [31:0] lanes(input logic [3:0] m);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, got, exp, $time);
      end
   endtask

   always @(posedge i_clk) cyc <= cyc + 1;

   // Bench memory: combinational read right-justified at the byte address, byte-masked writes.
   logic [10:0] ma1, ma2, ma3;
   always_comb begin
      ma1 = 11'(o_mem_addr + 11'd1);
      ma2 = 11'(o_mem_addr + 11'd2);
      ma3 = 11'(o_mem_addr + 11'd3);
      i_mem_rdata = {mem[ma3], mem[ma2], mem[ma1], mem[o_mem_addr]};
   end

   always @(posedge i_clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
         mem_ready <= 1'b1;
      end else if (o_mem_wren) begin
         for (int i = 0; i < 4; i++)
            if (o_mem_bmask[i]) mem[11'(o_mem_addr + 11'(i))] <= o_mem_wdata[8*i +: 8];
      end
   end

   // Random response back-pressure, forced low on request.
   initial begin
      i_rsp_ready = 1'b0;
      forever begin
         @(posedge i_clk);
         #1;
         i_rsp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: memory accesses against the access queue, responses against the response queue.
   always @(negedge i_clk) begin
      acc_t a;
      if (i_rst_n) begin
         if (o_mem_wren || (o_mem_bmask != 4'h0)) begin
            if (acc_q.size() == 0) begin
               check("unexpected_mem_access", 32'(o_mem_addr), 32'hFFFF_FFFF);
            end else begin
               a = acc_q.pop_front();
               check("mem_addr",  32'(o_mem_addr),  32'(a.addr));
               check("mem_bmask", 32'(o_mem_bmask), 32'(a.bmask));
               check("mem_wren",  32'(o_mem_wren),  32'(a.wren));
               check("mem_wdata", o_mem_wdata & lanes(a.bmask), a.wdata & lanes(a.bmask));
            end
         end
         if (o_rsp_valid) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_rsp", 32'(o_rsp_valid), 32'h0);
            end else begin
               if (!first_seen) begin
                  check("rsp_latency", 32'(cyc - hs_cyc), 32'(rsp_q[0].lat));
                  first_seen = 1'b1;
               end
               check("rsp_rdata", o_rsp_rdata, rsp_q[0].rdata);
               check("rsp_err", 32'(o_rsp_err), 32'(rsp_q[0].err));
               check("mem_quiet_in_resp",
                     32'(o_mem_wren) | 32'(o_mem_bmask) | 32'(o_mem_addr) | o_mem_wdata, 32'h0);
               check("req_ready_in_resp", 32'(o_req_ready), 32'h0);
               if (i_rsp_ready) begin
                  check("accesses_all_issued", 32'(acc_q.size()), 32'h0);
                  void'(rsp_q.pop_front());
                  first_seen = 1'b0;
               end
            end
         end
      end
   end

   // Issue one request: compute expected accesses/response from the byte model, then handshake.
   task automatic issue(input logic [31:0] addr, input logic wren, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata);
      logic        legal, mis, got;
      int          n;
      rsp_t        r;
      acc_t        a;
      logic [10:0] base, idx;
      logic [31:0] ld;
      base  = addr[10:0];
      n     = 1 << int'(size);
      mis   = ((size == 2'b01) && addr[0]) || ((size == 2'b10) && (addr[1:0] != 2'b00));
      legal = (size != 2'b11) && (addr[31:11] == 21'h0) && (!mis || SPLIT_EN);
      r.err = !legal;
      r.rdata = 32'h0;
      r.lat = 1;
      if (legal) begin
         if (mis) begin
            for (int k = 0; k < n; k++) begin
               a = '{addr: 11'(base + 11'(k)), bmask: 4'b0001, wren: wren,
                     wdata: 32'(wdata[8*k +: 8])};
               acc_q.push_back(a);
            end
            r.lat = 1 + n;
         end else begin
            a = '{addr: base, bmask: (n == 4) ? 4'hF : (n == 2) ? 4'h3 : 4'h1,
                  wren: wren, wdata: wdata};
            acc_q.push_back(a);
            r.lat = 2;
         end
         ld = 32'h0;
         for (int k = 0; k < n; k++) begin
            idx = 11'(base + 11'(k));
            if (wren) ref_mem[idx] = wdata[8*k +: 8];
            else      ld[8*k +: 8] = ref_mem[idx];
         end
         if (n == 1)      ld = uns ? {24'h0, ld[7:0]}  : {{24{ld[7]}}, ld[7:0]};
         else if (n == 2) ld = uns ? {16'h0, ld[15:0]} : {{16{ld[15]}}, ld[15:0]};
         r.rdata = wren ? 32'h0 : ld;
      end
      rsp_q.push_back(r);

      @(posedge i_clk);
      #1;
      i_req_valid = 1'b1;
      i_req_addr = addr;
      i_req_wren = wren;
      i_req_size = size;
      i_req_unsigned = uns;
      i_req_wdata = wdata;
      got = 1'b0;
      for (int t = 0; t < 100 && !got; t++) begin
         @(negedge i_clk);
         if (o_req_ready) begin
            got = 1'b1;
            hs_cyc = cyc;
         end
      end
      if (!got) begin
         check("req_handshake_timeout", 32'h0, 32'h1);
         rsp_q.delete();
         acc_q.delete();
         i_req_valid = 1'b0;
      end else begin
         @(posedge i_clk);
         #1;
         i_req_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((rsp_q.size() != 0) && (t < 200)) begin
         @(negedge i_clk);
         t++;
      end
      if (rsp_q.size() != 0) begin
         check("rsp_timeout", 32'h0, 32'h1);
         rsp_q.delete();
         acc_q.delete();
         first_seen = 1'b0;
      end
   endtask

   task automatic req(input logic [31:0] addr, input logic wren, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata);
      issue(addr, wren, size, uns, wdata);
      wait_done();
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_req_ready"}, 32'(o_req_ready), 32'h0);
      check({name, "_rsp_valid"}, 32'(o_rsp_valid), 32'h0);
      check({name, "_rsp"}, o_rsp_rdata | 32'(o_rsp_err), 32'h0);
      check({name, "_mem"}, 32'(o_mem_wren) | 32'(o_mem_bmask) | 32'(o_mem_addr) | o_mem_wdata,
            32'h0);
   endtask

   initial begin
      logic [7:0] saved [0:4];
      bit         seen;
      for (int i = 0; i < 2048; i++) ref_mem[i] = pat(i);
      i_rst_n = 1'b0;
      i_req_valid = 1'b0;
      i_req_addr = 32'h0;
      i_req_wren = 1'b0;
      i_req_size = 2'b00;
      i_req_unsigned = 1'b0;
      i_req_wdata = 32'h0;

      repeat (3) @(negedge i_clk);
      check_all_zero("reset");
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      check("ready_after_reset", 32'(o_req_ready), 32'h1);

      // Word store then load.
      req(32'h010, 1'b1, 2'b10, 1'b0, 32'hDEADBEEF);
      req(32'h010, 1'b0, 2'b10, 1'b0, 32'h0);
      // Byte store, signed and unsigned byte loads.
      req(32'h013, 1'b1, 2'b00, 1'b0, 32'h0000_0080);
      req(32'h013, 1'b0, 2'b00, 1'b0, 32'h0);
      req(32'h013, 1'b0, 2'b00, 1'b1, 32'h0);
      req(32'h012, 1'b0, 2'b01, 1'b0, 32'h0);
      // Misaligned half load.
      req(32'h001, 1'b0, 2'b01, 1'b0, 32'h0);
      req(32'h001, 1'b0, 2'b01, 1'b1, 32'h0);
      // Misaligned word store across the top of memory, then byte read-back.
      req(32'h7FE, 1'b1, 2'b10, 1'b0, 32'hA1B2C3D4);
      req(32'h7FE, 1'b0, 2'b10, 1'b1, 32'h0);
      req(32'h7FE, 1'b0, 2'b00, 1'b1, 32'h0);
      req(32'h7FF, 1'b0, 2'b00, 1'b1, 32'h0);
      req(32'h000, 1'b0, 2'b00, 1'b1, 32'h0);
      req(32'h001, 1'b0, 2'b00, 1'b1, 32'h0);
      // Illegal size and out-of-range address leave memory untouched.
      req(32'h020, 1'b1, 2'b11, 1'b0, 32'h11223344);
      req(32'h020, 1'b0, 2'b10, 1'b0, 32'h0);
      req(32'h020, 1'b0, 2'b11, 1'b0, 32'h0);

      // Out-of-range store with response back-pressure for 5 cycles.
      hold_low = 1'b1;
      issue(32'h800, 1'b1, 2'b10, 1'b0, 32'h12345678);
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge i_clk);
         seen = o_rsp_valid;
      end
      repeat (5) @(negedge i_clk);
      check("rsp_held_valid", 32'(o_rsp_valid), 32'h1);
      hold_low = 1'b0;
      wait_done();
      req(32'h000, 1'b0, 2'b10, 1'b0, 32'h0);

      // Randomized traffic.
      for (int i = 0; i < 300; i++) begin
         logic [31:0] ra;
         logic [1:0]  rs;
         ra = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 2047));
         rs = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         req(ra, 1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), $urandom());
      end

      // Reset in the middle of a store: no response, already-committed bytes remain.
      for (int k = 0; k < 5; k++) saved[k] = ref_mem[11'h200 + 11'(k)];
`ifdef LSU_MISALIGN_SPLIT_EN
      issue(32'h201, 1'b1, 2'b10, 1'b0, 32'h5A6B7C8D);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      for (int k = 2; k < 5; k++) ref_mem[11'h200 + 11'(k)] = saved[k];
`else
      issue(32'h200, 1'b1, 2'b10, 1'b0, 32'h5A6B7C8D);
      i_rst_n = 1'b0;
      for (int k = 0; k < 5; k++) ref_mem[11'h200 + 11'(k)] = saved[k];
`endif
      #1;
      check_all_zero("midop_reset");
      rsp_q.delete();
      acc_q.delete();
      first_seen = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      check("ready_after_midop_reset", 32'(o_req_ready), 32'h1);
      check("no_rsp_after_midop_reset", 32'(o_rsp_valid), 32'h0);
      req(32'h200, 1'b0, 2'b10, 1'b0, 32'h0);
      req(32'h204, 1'b0, 2'b00, 1'b1, 32'h0);
      req(32'h100, 1'b1, 2'b10, 1'b0, 32'hCAFEF00D);
      req(32'h100, 1'b0, 2'b10, 1'b0, 32'h0);

      repeat (3) @(negedge i_clk);
      check("rsp_queue_drained", 32'(rsp_q.size()), 32'h0);
      check("acc_queue_drained", 32'(acc_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/lsu_mem_master.md
LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

Interface
REQ-001 SHALL have ports: i_clk input 1 (single clock); i_rst_n input 1 (reset; asynchronous, active-low).
REQ-002 SHALL have ports: i_req_valid input 1, request present; o_req_ready output 1, request accepted when both high.
REQ-003 SHALL have ports: i_req_addr input 32, byte address; i_req_wren input 1, 1=store 0=load; i_req_size input 2, 00 byte 01 half 10 word 11 illegal; i_req_unsigned input 1, zero-extend load; i_req_wdata input 32, store data right-justified.
REQ-004 SHALL have ports: o_rsp_valid output 1; i_rsp_ready input 1; o_rsp_rdata output 32, extended load data (0 for stores); o_rsp_err output 1.
REQ-005 SHALL have ports: o_mem_addr output 11; o_mem_wdata output 32, right-justified; o_mem_bmask output 4, 1111 word, 0011 half, 0001 byte; o_mem_wren output 1; i_mem_rdata input 32, combinational read, returned right-shifted by byte offset.

Function
REQ-006 SHALL implement FSM IDLE, ACCESS, SPLIT, RESP; o_req_ready=1 only in IDLE.
REQ-007 SHALL latch addr/size/wren/unsigned/wdata on handshake in IDLE; IDLE->ACCESS, or IDLE->RESP with o_rsp_err=1 and no memory write when size=11 or addr[31:11]!=0.
REQ-008 SHALL, in ACCESS for aligned requests (half addr[0]=0, word addr[1:0]=00, any byte), drive o_mem_addr=addr[10:0], size-encoded bmask, wren=i_req_wren for exactly one cycle, capture i_mem_rdata in that cycle, then go to RESP; store commits on the edge ending ACCESS.
REQ-009 SHALL extend loads: byte from bits[7:0], half from bits[15:0], sign- or zero-extended per unsigned; word unchanged.
REQ-010 SHALL hold o_rsp_valid=1 with stable rdata/err in RESP until i_rsp_ready=1, then return to IDLE; earliest next accept is the following cycle.
REQ-011 SHALL drive o_mem_wren=0, o_mem_bmask=0000, o_mem_addr=0, o_mem_wdata=0 in IDLE and RESP.
REQ-012 SHALL give aligned request latency: handshake at cycle N, memory access N+1, o_rsp_valid from N+2.
REQ-013 SHALL compute addr+k with 11-bit wrap (0x7FF+1 -> 0x000).

Reset
REQ-014 SHALL, on i_rst_n low, asynchronously force IDLE and all outputs 0 except o_req_ready, which is 1 once reset deasserts.
REQ-015 SHALL abort any operation on reset mid-access; bytes already written stay written; no response is issued.

Configuration
REQ-016 SHALL support macro LSU_MISALIGN_SPLIT_EN: when defined, misaligned half/word go ACCESS->SPLIT, issuing N (2 or 4) consecutive byte accesses (bmask 0001, addr+k, wdata byte k) for k=0..N-1, loads assembling byte k into bits[8k+7:8k], then RESP with err=0.
REQ-017 SHALL, without LSU_MISALIGN_SPLIT_EN, route misaligned half/word IDLE->RESP with o_rsp_err=1, rdata=0, no memory access.

Structure
REQ-018 SHALL place the size encoding enum, FSM state enum, and bmask constants (BMASK_BYTE/HALF/WORD) in shared package lsu_pkg.
REQ-019 SHALL use one sub-module, lsu_load_ext (combinational size/sign extension).

Verification
REQ-020 SHALL cover: word store 0xDEADBEEF @0x010 then word load @0x010 -> bmask 1111 on store, rdata 0xDEADBEEF, o_rsp_valid at cycle N+2.
REQ-021 SHALL cover: byte store 0x80 @0x013, signed byte load @0x013 -> 0xFFFFFF80; unsigned -> 0x00000080.
REQ-022 SHALL cover: half load @0x001 -> with macro, two byte accesses @0x001, 0x002, err=0; without macro, err=1 and no mem_wren pulse.
REQ-023 SHALL cover: word store @0x7FE with macro -> byte writes @0x7FE, 0x7FF, 0x000, 0x001.
REQ-024 SHALL cover: size=11 or addr=0x800 -> err=1 and memory untouched; i_rsp_ready held low 5 cycles -> response held stable.
REQ-025 SHALL cover: reset asserted during SPLIT -> IDLE, o_rsp_valid=0, o_req_ready=1 after release.
